aes_key_expander: RTL and testbench
===================================

Name: aes_key_expander

Overview:
- Iterative AES key-schedule engine that sits directly upstream of the cipher and inverse-cipher cores.
- Latches a cipher key of nk 32-bit words and generates one expanded word per cycle into an internal round-key store.
- Serves any 128-bit round key through a registered read port, so cipher/Inv_cipher index keys by round number instead of expanding the key themselves.
- One instance per key length (nk = 4, 6, 8).

Parameters:
- nk, 4, key length in 32-bit words; legal values 4, 6, 8 only.
- nr, nk+6, number of rounds (derived, not overridable).
- nw, 4*(nr+1), total expanded words: 44, 52 or 60.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request; key_in is sampled on the same edge.
- key_in  input  nk*32  cipher key; byte 0 in the MSBs, w[0] = key_in[nk*32-1 -: 32].
- busy  output  1  expansion in progress.
- done  output  1  full schedule valid; level signal.
- rd_round  input  4  round index to read, 0..nr.
- rd_key  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in the MSBs.

Behaviour:
- Reset (reset=0, asynchronous): busy=0, done=0, rd_key=0, word counter=0, rcon=8'h01. The word store need not be cleared. Reset mid-expansion aborts it; after release the block idles until the next start.
- Start edge T (start=1): writes w[0..nk-1] from key_in, sets i=nk, phase=0, rcon=01, busy=1, done=0.
- Each later edge while busy:
  - temp = w[i-1].
  - If phase==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon <= xtime(rcon) (01,02,04,08,10,20,40,80,1b,36).
  - Else if nk==8 and phase==4: temp = SubWord(temp).
  - w[i] = w[i-nk] ^ temp; i++; phase wraps to 0 after nk-1.
  - Use no modulo/divide: phase is a counter.
- Completion: on the edge writing w[nw-1], busy falls and done rises together. done rises at edge T+40 (nk=4), T+46 (nk=6), T+52 (nk=8). done stays high until the next start or reset.
- start while busy: restart from the new key_in; the previous expansion is discarded.
- start while done: done drops at that edge and a new expansion begins.
- start coincident with reset low: reset wins.
- Read port:
  - rd_key is registered: it reflects rd_round sampled on the previous edge (1-cycle latency).
  - rd_round > nr returns 0.
  - Reads while busy return the store contents as-is. Consumers must wait for done.
- RotWord {a,b,c,d} -> {b,c,d,a}. SubWord applies the AES S-box to each byte.
- One word per cycle max: 4 S-box lookups/cycle, no combinational path longer than S-box + two XORs.

Decomposition:
- Package aes_pkg: nr/nw derivation function, xtime function, RotWord function, S-box constant table (shared with cipher).
- Sub-module aes_sbox: combinational 8-bit forward S-box, instantiated 4x for SubWord.
- Controller, counters, store and read mux live in aes_key_expander.

Test Plan:
- nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, start -> done exactly 40 cycles later; rd_round=10 -> rd_key d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later.
- nk=4, key 000102030405060708090a0b0c0d0e0f -> round 0 = key; round 1 d6aa74fdd2af72fadaa678f1d6ab76fe; round 10 13111d7fe3944a17f307a78b4d2b30c5.
- nk=6, key 000102…1617 -> done after 46 cycles; round 12 a4970a331a78dc09c418c271e3a41d5d. nk=8, key 000102…1e1f -> done after 52 cycles; round 14 24fc79ccbf0979e9371ac23c6d68de36.
- Restart: nk=4, start key A, re-start with key 000102…0f at cycle 20 -> done 40 cycles after the second start; round 10 = 13111d7f…4d2b30c5.
- Reset pulse (low 1 cycle, async mid-cycle) at cycle 15 of an expansion -> busy=0, done=0, rd_key=0 immediately; no done without a new start. rd_round=11 with nk=4 -> rd_key=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers: round/word-count derivation, GF(2^8) xtime, RotWord and the forward S-box.
// The cipher cores use the same S-box table.
package aes_pkg;

    typedef enum logic [1:0] {
        KX_IDLE,
        KX_BUSY,
        KX_DONE
    } kx_state_e;

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic int nw_of(input int nk);
        return 4 * (nk + 7);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule: one expanded word per cycle into a round-key store,
// with a registered 128-bit read port indexed by round number. nk must be 4, 6 or 8.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int nk = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [nk*32-1:0] key_in,
    output logic            busy,
    output logic            done,
    input  logic [3:0]      rd_round,
    output logic [127:0]    rd_key
);

    localparam int nr = nr_of(nk);
    localparam int nw = nw_of(nk);

    kx_state_e   state, nxt_state;
    logic [5:0]  idx;
    logic [2:0]  phase;
    logic [7:0]  rcon;

    // win holds w[i-nk]..w[i-1] so the datapath never goes through the store's read mux
    logic [31:0] win [nk];
    logic [31:0] store [nw];
    logic [31:0] sub, temp, new_w;
    logic [5:0]  rbase;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (win[nk-1][8*b +: 8]),
            .out_byte (sub[8*b +: 8])
        );
    end

    // SubWord is bytewise, so SubWord(RotWord(x)) == RotWord(SubWord(x)): rotate after the S-boxes
    always_comb begin
        temp = win[nk-1];
        if (phase == 3'd0)
            temp = rot_word(sub) ^ {rcon, 24'h0};
        else if (nk == 8 && phase == 3'd4)
            temp = sub;
        new_w = win[0] ^ temp;
    end

    always_comb begin
        nxt_state = state;
        if (start)
            nxt_state = KX_BUSY;
        else if (state == KX_BUSY && idx == 6'(nw - 1))
            nxt_state = KX_DONE;
        busy = (state == KX_BUSY);
        done = (state == KX_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= KX_IDLE;
            idx   <= '0;
            phase <= '0;
            rcon  <= 8'h01;
        end else begin
            state <= nxt_state;
            if (start) begin
                idx   <= 6'(nk);
                phase <= '0;
                rcon  <= 8'h01;
            end else if (state == KX_BUSY) begin
                idx   <= idx + 6'd1;
                phase <= (phase == 3'(nk - 1)) ? 3'd0 : phase + 3'd1;
                if (phase == 3'd0)
                    rcon <= xtime(rcon);
            end
        end
    end

    // Store and window carry no reset; the control state alone decides validity
    always_ff @(posedge clk) begin
        if (start) begin
            for (int j = 0; j < nk; j++) begin
                win[j]   <= key_in[nk*32-1-32*j -: 32];
                store[j] <= key_in[nk*32-1-32*j -: 32];
            end
        end else if (state == KX_BUSY) begin
            for (int j = 0; j < nk - 1; j++)
                win[j] <= win[j+1];
            win[nk-1]  <= new_w;
            store[idx] <= new_w;
        end
    end

    assign rbase = {rd_round, 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rd_key <= '0;
        else if (rd_round <= 4'(nr))
            rd_key <= {store[rbase], store[rbase + 6'd1], store[rbase + 6'd2], store[rbase + 6'd3]};
        else
            rd_key <= '0;
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: one instance per key length, checked against a textbook
// key-schedule model whose S-box is derived from the GF(2^8) inverse plus affine map.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
    logic [3:0]   rd_round;
    logic         busy4, busy6, busy8, done4, done6, done8;
    logic [127:0] rdk4, rdk6, rdk8;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sbox_tab [256];

    always #5 clk = ~clk;

    aes_key_expander #(.nk(4)) dut4 (.clk(clk), .reset(reset), .start(start), .key_in(key4),
        .busy(busy4), .done(done4), .rd_round(rd_round), .rd_key(rdk4));
    aes_key_expander #(.nk(6)) dut6 (.clk(clk), .reset(reset), .start(start), .key_in(key6),
        .busy(busy6), .done(done6), .rd_round(rd_round), .rd_key(rdk6));
    aes_key_expander #(.nk(8)) dut8 (.clk(clk), .reset(reset), .start(start), .key_in(key8),
        .busy(busy8), .done(done8), .rd_round(rd_round), .rd_key(rdk8));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // key is left-aligned in 256 bits; returns round r, or 0 past the last round
    function automatic logic [127:0] ref_round(input int nkk, input logic [255:0] key, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        if (r > nkk + 6) return 128'h0;
        for (int i = 0; i < nkk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nkk; i < 4 * (nkk + 7); i++) begin
            t = w[i-1];
            if (i % nkk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nkk > 6 && i % nkk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nkk] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(input logic [255:0] k);
        key4 = k[255:128];
        key6 = k[255:64];
        key8 = k;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_read(input int r);
        rd_round = 4'(r);
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_checks++;
        if ({busy4, busy6, busy8, done4, done6, done8} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b want=000000", {busy4, busy6, busy8, done4, done6, done8});
        end
        n_checks++;
        if ((rdk4 | rdk6 | rdk8) !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_rd_key got=%h want=0", rdk4 | rdk6 | rdk8);
        end
    endtask

    task automatic test_vectors();
        int d4 = 0, d6 = 0, d8 = 0;
        logic [255:0] k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        set_key(k);
        do_start();
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 39) begin
                n_checks++;
                if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_before_done4 got busy=%b done=%b want busy=1 done=0", busy4, done4);
                end
            end
            if (done4 === 1'b1 && d4 == 0) d4 = c;
            if (done6 === 1'b1 && d6 == 0) d6 = c;
            if (done8 === 1'b1 && d8 == 0) d8 = c;
        end
        n_checks++;
        if (d4 != 40 || d6 != 46 || d8 != 52) begin
            n_fail++;
            $display("FAIL done_latency got=%0d/%0d/%0d want=40/46/52 (0 means never)", d4, d6, d8);
        end
        n_checks++;
        if (done4 !== 1'b1 || busy4 !== 1'b0 || done8 !== 1'b1) begin
            n_fail++;
            $display("FAIL done_level got done4=%b busy4=%b done8=%b want 1/0/1", done4, busy4, done8);
        end
        do_read(0);
        n_checks++;
        if (rdk4 !== 128'h000102030405060708090a0b0c0d0e0f) begin
            n_fail++;
            $display("FAIL nk4_round0 got=%h want=000102030405060708090a0b0c0d0e0f", rdk4);
        end
        do_read(1);
        n_checks++;
        if (rdk4 !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe) begin
            n_fail++;
            $display("FAIL nk4_round1 got=%h want=d6aa74fdd2af72fadaa678f1d6ab76fe", rdk4);
        end
        do_read(10);
        n_checks++;
        if (rdk4 !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
            n_fail++;
            $display("FAIL nk4_round10 got=%h want=13111d7fe3944a17f307a78b4d2b30c5", rdk4);
        end
        do_read(12);
        n_checks++;
        if (rdk6 !== 128'ha4970a331a78dc09c418c271e3a41d5d) begin
            n_fail++;
            $display("FAIL nk6_round12 got=%h want=a4970a331a78dc09c418c271e3a41d5d", rdk6);
        end
        do_read(14);
        n_checks++;
        if (rdk8 !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
            n_fail++;
            $display("FAIL nk8_round14 got=%h want=24fc79ccbf0979e9371ac23c6d68de36", rdk8);
        end
    endtask

    task automatic test_fips_key();
        set_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        do_start();
        for (int c = 0; c < 60; c++) tick();
        do_read(10);
        n_checks++;
        if (rdk4 !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_fail++;
            $display("FAIL fips_round10 got=%h want=d014f9a8c9ee2589e13f0cc8b6630ca6", rdk4);
        end
    endtask

    task automatic test_random();
        logic [255:0] k;
        logic [127:0] e4, e6, e8;
        for (int t = 0; t < 4; t++) begin
            for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
            set_key(k);
            do_start();
            for (int c = 0; c < 60; c++) tick();
            for (int r = 0; r < 16; r++) begin
                do_read(r);
                e4 = ref_round(4, k, r);
                e6 = ref_round(6, k, r);
                e8 = ref_round(8, k, r);
                n_checks++;
                if (rdk4 !== e4 || rdk6 !== e6 || rdk8 !== e8) begin
                    n_fail++;
                    $display("FAIL rand_key%0d_round%0d got=%h/%h/%h want=%h/%h/%h",
                             t, r, rdk4, rdk6, rdk8, e4, e6, e8);
                end
            end
        end
    endtask

    task automatic test_restart();
        int d4 = 0;
        logic [255:0] k;
        for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
        set_key(k);
        do_start();
        for (int c = 1; c < 20; c++) tick();
        set_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        do_start();
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (done4 === 1'b1 && d4 == 0) d4 = c;
        end
        n_checks++;
        if (d4 != 40) begin
            n_fail++;
            $display("FAIL restart_latency got=%0d want=40", d4);
        end
        do_read(10);
        n_checks++;
        if (rdk4 !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
            n_fail++;
            $display("FAIL restart_round10 got=%h want=13111d7fe3944a17f307a78b4d2b30c5", rdk4);
        end
    endtask

    task automatic test_start_while_done();
        do_start();
        n_checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b1 || done8 !== 1'b0 || busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL start_while_done got done4=%b busy4=%b done8=%b busy8=%b want 0/1/0/1",
                     done4, busy4, done8, busy8);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_done = 0;
        set_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        rd_round = 4'd0;
        do_start();
        for (int c = 1; c < 15; c++) tick();
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || rdk4 !== 128'h0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got busy4=%b done4=%b rdk4=%h busy8=%b want 0/0/0/0",
                     busy4, done4, rdk4, busy8);
        end
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy4 !== 1'b0 || busy6 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_under_reset got busy4=%b busy6=%b want 0/0", busy4, busy6);
        end
        for (int c = 0; c < 60; c++) begin
            tick();
            if (done4 === 1'b1 || busy4 === 1'b1) seen_done = 1;
        end
        n_checks++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL idle_after_reset got activity=1 want=0");
        end
        do_read(11);
        n_checks++;
        if (rdk4 !== 128'h0) begin
            n_fail++;
            $display("FAIL nk4_round11 got=%h want=0", rdk4);
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        rd_round = 4'd0;
        set_key(256'h0);
        build_sbox();
        #12;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        test_vectors();
        test_fips_key();
        test_random();
        test_restart();
        test_start_while_done();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
